wptr_full_level: RTL and testbench

//  Write-side pointer and status generator for the async FIFO, write clock domain.

---
 rtl/wptr_full_level.sv | 112 +++++++++++
 tb/tb_wptr_full_level.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_level.sv
// wptr_full_level
//   Write-side pointer and status generator for the async FIFO (wclk domain).
//   Produces the RAM write address, the Gray write pointer for the
//   wptr->rclk synchroniser, full / almost-full flags, a conservative
//   occupancy level, a sticky overflow flag and a saturating count of
//   dropped writes.
//
// Ports
//   wclk          in   write clock
//   wrst_n        in   synchronous active-low reset
//   winc          in   write request
//   wq2_rptr      in   read Gray pointer, synchronised into wclk
//   afull_thresh  in   almost-full threshold, in entries
//   woverflow_clr in   clears woverflow and wovf_cnt
//   waddr         out  RAM write address (binary)
//   wptr          out  write Gray pointer
//   wfull         out  FIFO full
//   awfull        out  level >= afull_thresh
//   wlevel        out  occupancy seen from the write side, 0..DEPTH
//   woverflow     out  sticky: a write was dropped
//   wovf_cnt      out  saturating count of dropped writes
module wptr_full_level #(
    parameter int ADDRSIZE = 4,
    parameter int OVFCNT_W = 8
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                woverflow_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                awfull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow,
    output logic [OVFCNT_W-1:0] wovf_cnt
);

    localparam logic [ADDRSIZE:0]   DEPTH   = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0]   ONE_PTR = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [OVFCNT_W-1:0] ONE_CNT = {{(OVFCNT_W-1){1'b0}}, 1'b1};

    logic [ADDRSIZE:0]   wbin;
    logic [ADDRSIZE:0]   wbinnext;
    logic [ADDRSIZE:0]   wgraynext;
    logic [ADDRSIZE:0]   rbin;
    logic [ADDRSIZE:0]   lvl;
    logic                accept;
    logic                drop;
    logic                wfull_next;
    logic                awfull_next;
    logic [ADDRSIZE:0]   wlevel_next;
    logic                woverflow_next;
    logic [OVFCNT_W-1:0] wovf_cnt_next;

    assign waddr = wbin[ADDRSIZE-1:0];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    always_comb begin
        accept    = winc & ~wfull;
        drop      = winc & wfull;
        wbinnext  = wbin + (accept ? ONE_PTR : '0);
        wgraynext = (wbinnext >> 1) ^ wbinnext;
        lvl       = wbinnext - rbin;

        // lvl > DEPTH can only come from an illegal read pointer; report it as full.
        wfull_next  = (lvl >= DEPTH);
        wlevel_next = (lvl > DEPTH) ? DEPTH : lvl;
        awfull_next = (lvl >= afull_thresh);

        woverflow_next = drop | (woverflow & ~woverflow_clr);

        wovf_cnt_next = wovf_cnt;
        if (woverflow_clr && drop) begin
            wovf_cnt_next = ONE_CNT;
        end else if (woverflow_clr) begin
            wovf_cnt_next = '0;
        end else if (drop && !(&wovf_cnt)) begin
            wovf_cnt_next = wovf_cnt + ONE_CNT;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr      <= '0;
            wfull     <= 1'b0;
            awfull    <= 1'b0;
            wlevel    <= '0;
            woverflow <= 1'b0;
            wovf_cnt  <= '0;
        end else begin
            wbin      <= wbinnext;
            wptr      <= wgraynext;
            wfull     <= wfull_next;
            awfull    <= awfull_next;
            wlevel    <= wlevel_next;
            woverflow <= woverflow_next;
            wovf_cnt  <= wovf_cnt_next;
        end
    end

endmodule

// File: tb/tb_wptr_full_level.sv
// tb_wptr_full_level
//   Directed self-checking bench for wptr_full_level (ADDRSIZE=4, OVFCNT_W=8).
//   Each step drives inputs, pushes the predicted post-edge outputs into a
//   queue, clocks once and pops/compares against the DUT.
module tb_wptr_full_level;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic [4:0] wq2_rptr = '0;
    logic [4:0] afull_thresh = '0;
    logic       woverflow_clr = 1'b0;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       awfull;
    logic [4:0] wlevel;
    logic       woverflow;
    logic [7:0] wovf_cnt;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       wfull;
        logic       awfull;
        logic [4:0] wlevel;
        logic       woverflow;
        logic [7:0] wovf_cnt;
    } exp_t;

    exp_t sb[$];

    // reference model state
    int m_wbin  = 0;
    int m_wfull = 0;
    int m_ovf   = 0;
    int m_cnt   = 0;

    wptr_full_level #(.ADDRSIZE(4), .OVFCNT_W(8)) dut (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .winc          (winc),
        .wq2_rptr      (wq2_rptr),
        .afull_thresh  (afull_thresh),
        .woverflow_clr (woverflow_clr),
        .waddr         (waddr),
        .wptr          (wptr),
        .wfull         (wfull),
        .awfull        (awfull),
        .wlevel        (wlevel),
        .woverflow     (woverflow),
        .wovf_cnt      (wovf_cnt)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] bin2gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step: drive, predict, push, clock, pop and compare.
    task automatic step(input logic rst_n, input logic inc, input int rb,
                        input int thresh, input logic clr);
        exp_t e;
        int   acc, drp, nb, lvl;
        wrst_n        = rst_n;
        winc          = inc;
        wq2_rptr      = bin2gray(rb);
        afull_thresh  = thresh[4:0];
        woverflow_clr = clr;

        if (!rst_n) begin
            m_wbin = 0; m_wfull = 0; m_ovf = 0; m_cnt = 0;
            e = '{4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0};
        end else begin
            acc = (inc && m_wfull == 0) ? 1 : 0;
            drp = (inc && m_wfull != 0) ? 1 : 0;
            nb  = (m_wbin + acc) % 32;
            lvl = (nb - rb + 64) % 32;
            if (clr && drp != 0)      m_cnt = 1;
            else if (clr)             m_cnt = 0;
            else if (drp != 0 && m_cnt < 255) m_cnt = m_cnt + 1;
            m_ovf   = (drp != 0 || (m_ovf != 0 && !clr)) ? 1 : 0;
            m_wbin  = nb;
            m_wfull = (lvl >= 16) ? 1 : 0;
            e.waddr     = 4'(nb % 16);
            e.wptr      = bin2gray(nb);
            e.wfull     = (lvl >= 16);
            e.awfull    = (lvl >= thresh);
            e.wlevel    = 5'((lvl > 16) ? 16 : lvl);
            e.woverflow = (m_ovf != 0);
            e.wovf_cnt  = 8'(m_cnt);
        end
        sb.push_back(e);

        @(posedge wclk);
        #1;
        e = sb.pop_front();
        check("waddr",     32'(waddr),     32'(e.waddr));
        check("wptr",      32'(wptr),      32'(e.wptr));
        check("wfull",     32'(wfull),     32'(e.wfull));
        check("awfull",    32'(awfull),    32'(e.awfull));
        check("wlevel",    32'(wlevel),    32'(e.wlevel));
        check("woverflow", 32'(woverflow), 32'(e.woverflow));
        check("wovf_cnt",  32'(wovf_cnt),  32'(e.wovf_cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wptr"},   32'(wptr),      32'd0);
        check({tag, "_waddr"},  32'(waddr),     32'd0);
        check({tag, "_wfull"},  32'(wfull),     32'd0);
        check({tag, "_awfull"}, 32'(awfull),    32'd0);
        check({tag, "_wlevel"}, 32'(wlevel),    32'd0);
        check({tag, "_ovf"},    32'(woverflow), 32'd0);
        check({tag, "_cnt"},    32'(wovf_cnt),  32'd0);
    endtask

    initial begin
        logic [4:0] prev_wptr;
        int         rb_now;
        bit         wrapped;

        // 1: reset with winc held high
        step(1'b0, 1'b1, 0, 12, 1'b0);
        step(1'b0, 1'b1, 0, 12, 1'b0);
        check_all_zero("rst");
        step(1'b1, 1'b0, 0, 12, 1'b0);
        check("rel_wfull",  32'(wfull),  32'd0);
        check("rel_wlevel", 32'(wlevel), 32'd0);

        // 2: fill
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 0, 12, 1'b0);
            if (i == 11) check("fill11_awfull", 32'(awfull), 32'd0);
            if (i == 12) begin
                check("fill12_awfull", 32'(awfull), 32'd1);
                check("fill12_wlevel", 32'(wlevel), 32'd12);
            end
            if (i == 15) check("fill15_wfull", 32'(wfull), 32'd0);
        end
        check("full_wfull",  32'(wfull),  32'd1);
        check("full_wlevel", 32'(wlevel), 32'd16);
        check("full_wptr",   32'(wptr),   32'b11000);
        check("full_waddr",  32'(waddr),  32'd0);

        // 3: overflow
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0, 12, 1'b0);
        check("ovf_wptr", 32'(wptr),      32'b11000);
        check("ovf_flag", 32'(woverflow), 32'd1);
        check("ovf_cnt",  32'(wovf_cnt),  32'd3);
        step(1'b1, 1'b1, 0, 12, 1'b1);
        check("clrdrop_flag", 32'(woverflow), 32'd1);
        check("clrdrop_cnt",  32'(wovf_cnt),  32'd1);
        step(1'b1, 1'b0, 0, 12, 1'b1);
        check("clr_flag", 32'(woverflow), 32'd0);
        check("clr_cnt",  32'(wovf_cnt),  32'd0);

        // 4: drain
        step(1'b1, 1'b0, 4, 12, 1'b0);
        check("drain4_wfull",  32'(wfull),  32'd0);
        check("drain4_wlevel", 32'(wlevel), 32'd12);
        check("drain4_awfull", 32'(awfull), 32'd1);
        step(1'b1, 1'b0, 5, 12, 1'b0);
        check("drain5_wlevel", 32'(wlevel), 32'd11);
        check("drain5_awfull", 32'(awfull), 32'd0);

        // 5: wrap with the reader trailing so the level stays at 3
        wrapped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prev_wptr = wptr;
            rb_now = (m_wbin + 1 - 3 + 32) % 32;
            if (m_wbin == 31) wrapped = 1'b1;
            step(1'b1, 1'b1, rb_now, 12, 1'b0);
            check("wrap_gray1bit", 32'($countones(prev_wptr ^ wptr)), 32'd1);
            check("wrap_wlevel",   32'(wlevel), 32'd3);
            check("wrap_wfull",    32'(wfull),  32'd0);
        end
        check("wrap_seen", 32'(wrapped), 32'd1);

        // 6: threshold edges and reset while full
        step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        check("th0_awfull", 32'(awfull), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 0, 17, 1'b0);
        check("th17_wfull",  32'(wfull),  32'd1);
        check("th17_awfull", 32'(awfull), 32'd0);
        step(1'b1, 1'b1, 0, 17, 1'b0);
        step(1'b1, 1'b1, 0, 17, 1'b0);
        check("prerst_ovf", 32'(woverflow), 32'd1);
        step(1'b0, 1'b1, 0, 17, 1'b1);
        check_all_zero("fullrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
